// File: rtl/mem_seq_pkg.sv
// Shared types and helpers for the memory test sequencer: state encoding,
// byte-lane select values and the deterministic test pattern.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_SHOW  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;  // bits [7:0]
  localparam logic [1:0] LANE_B1 = 2'd1;  // bits [15:8]
  localparam logic [1:0] LANE_B2 = 2'd2;  // bits [23:16]
  localparam logic [1:0] LANE_B3 = 2'd3;  // bits [31:24]

  // The word address lands in every byte so each byte lane is distinct per word.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [5:0] addr);
    return seed ^ {4{2'b00, addr}};
  endfunction

endpackage

// File: rtl/mem_seq_dwell_ctr.sv
// Dwell counter for the SHOW phase: pulses step once every DWELL enabled
// cycles and restarts from zero whenever it is disabled.
module mem_seq_dwell_ctr #(
  parameter int DWELL = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic step
);

  localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign step = en && (cnt == LAST);

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || !en || step) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mem_test_sequencer.sv
// Memory test sequencer: writes a pattern, reads it back and checks it, then
// steps the LED byte select over every word. Optional MEM_SEQ_ERR_INJECT_EN
// adds an Err_Inject input that corrupts bit 0 of the word written to address 1.
module mem_test_sequencer
  import mem_seq_pkg::*;
#(
  parameter int          NUM_WORDS = 4,
  parameter logic [31:0] SEED      = 32'h0F0F_0F0F,
  parameter int          DWELL     = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
`ifdef MEM_SEQ_ERR_INJECT_EN
  input  logic        Err_Inject,
`endif
  input  logic [31:0] Mem_RData,
  output logic        Mem_Read,
  output logic        Mem_Write,
  output logic [5:0]  Mem_Addr,
  output logic [31:0] Mem_WData,
  output logic [1:0]  MUX,
  output logic        Busy,
  output logic        Done,
  output logic        Pass,
  output logic [3:0]  Err_Cnt
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  state_t      state, state_nxt;
  logic [5:0]  idx;
  logic [1:0]  lane;
  logic [3:0]  err_cnt;
  logic        pass;
  logic        step;
  logic        inject;
  logic [5:0]  exp_addr;
  logic [3:0]  err_after;

`ifdef MEM_SEQ_ERR_INJECT_EN
  logic inject_q;
  always_ff @(posedge Clk) begin
    if (!Reset)                      inject_q <= 1'b0;
    else if (state == S_IDLE && Start) inject_q <= Err_Inject;
  end
  assign inject = inject_q;
`else
  assign inject = 1'b0;
`endif

  mem_seq_dwell_ctr #(.DWELL(DWELL)) u_dwell (
    .clk  (Clk),
    .rst_n(Reset),
    .en   (state == S_SHOW),
    .step (step)
  );

  // Read data arrives one cycle late, so READ checks the previous address and
  // CHECK picks up the final word.
  always_comb begin
    exp_addr  = (state == S_CHECK) ? LAST_IDX : idx - 6'd1;
    err_after = err_cnt;
    if (((state == S_READ) && (idx != '0)) || (state == S_CHECK)) begin
      if ((Mem_RData != pattern(SEED, exp_addr)) && (err_cnt != 4'hF))
        err_after = err_cnt + 4'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = S_WRITE;
      S_WRITE: if (idx == LAST_IDX) state_nxt = S_READ;
      S_READ:  if (idx == LAST_IDX) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_SHOW;
      S_SHOW:  if (step && lane == LANE_B3 && idx == LAST_IDX) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      idx     <= '0;
      lane    <= LANE_B0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          idx     <= '0;
          err_cnt <= '0;
          pass    <= 1'b0;
        end
        S_WRITE: idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        S_READ: begin
          err_cnt <= err_after;
          idx     <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
        S_CHECK: begin
          err_cnt <= err_after;
          pass    <= (err_after == 4'd0);
        end
        S_SHOW: if (step) begin
          lane <= lane + 2'd1;
          if (lane == LANE_B3) idx <= (idx == LAST_IDX) ? 6'd0 : idx + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred
  // for states that do not drive it.
  always_comb begin
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    Mem_Addr  = '0;
    Mem_WData = '0;
    MUX       = LANE_B0;
    Done      = 1'b0;
    Busy      = (state != S_IDLE);
    case (state)
      S_WRITE: begin
        Mem_Write = 1'b1;
        Mem_Addr  = idx;
        Mem_WData = pattern(SEED, idx) ^ {31'd0, inject && (idx == 6'd1)};
      end
      S_READ: begin
        Mem_Read = 1'b1;
        Mem_Addr = idx;
      end
      S_SHOW: begin
        Mem_Read = 1'b1;
        Mem_Addr = idx;
        MUX      = lane;
      end
      S_DONE:  Done = 1'b1;
      default: ;
    endcase
  end

  assign Pass    = pass;
  assign Err_Cnt = err_cnt;

endmodule
